// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register-file write-back path.
package regfile_pkg;
  localparam int RF_DATA_WIDTH  = 64;
  localparam int RF_REG_COUNT   = 256;
  localparam int RF_ADDR_WIDTH  = $clog2(RF_REG_COUNT);
  localparam int RF_SRC_COUNT   = 6;
  localparam int RF_WRITE_PORTS = 4;

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RR_PTR_WIDTH = ptr_width(RF_SRC_COUNT);

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] addr;
    logic [RF_DATA_WIDTH-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_writeback_arbiter_picker.sv
// Combinational round-robin picker: up to WRITE_PORTS grants per scan,
// skipping any source whose address matches an earlier grant in the same scan.
module rr_multi_grant_picker
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH  = RF_ADDR_WIDTH,
  parameter int SRC_COUNT   = RF_SRC_COUNT,
  parameter int WRITE_PORTS = RF_WRITE_PORTS,
  localparam int SW = ptr_width(SRC_COUNT),
  localparam int PW = ptr_width(WRITE_PORTS)
) (
  input  logic [SRC_COUNT-1:0]   valid,
  input  logic [ADDR_WIDTH-1:0]  addrs [SRC_COUNT],
  input  logic [SW-1:0]          ptr,
  output logic [SRC_COUNT-1:0]   grant,
  output logic [SW-1:0]          port_src [WRITE_PORTS],
  output logic [WRITE_PORTS-1:0] port_vld
);
  logic [SW:0]           pos;
  logic [SW-1:0]         sidx;
  logic [PW:0]           cnt;
  logic                  clash;
  logic [ADDR_WIDTH-1:0] taken [WRITE_PORTS];

  always_comb begin
    grant    = '0;
    port_vld = '0;
    port_src = '{default: '0};
    taken    = '{default: '0};
    pos      = '0;
    sidx     = '0;
    cnt      = '0;
    clash    = 1'b0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      pos = {1'b0, ptr} + (SW+1)'(i);
      if (pos >= (SW+1)'(SRC_COUNT)) pos = pos - (SW+1)'(SRC_COUNT);
      sidx  = pos[SW-1:0];
      clash = 1'b0;
      for (int k = 0; k < WRITE_PORTS; k++) begin
        if (((PW+1)'(k) < cnt) && (taken[PW'(k)] == addrs[sidx])) clash = 1'b1;
      end
      // k-th grant in scan order lands on write port k
      if (valid[sidx] && (cnt < (PW+1)'(WRITE_PORTS)) && !clash) begin
        grant[sidx]              = 1'b1;
        port_vld[cnt[PW-1:0]]    = 1'b1;
        port_src[cnt[PW-1:0]]    = sidx;
        taken[cnt[PW-1:0]]       = addrs[sidx];
        cnt                      = cnt + (PW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Write-back arbiter: grants source handshakes round-robin and registers the
// winners onto the register-file write ports one cycle later.
module regfile_writeback_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = RF_DATA_WIDTH,
  parameter int REG_COUNT   = RF_REG_COUNT,
  parameter int ADDR_WIDTH  = $clog2(REG_COUNT),
  parameter int SRC_COUNT   = RF_SRC_COUNT,
  parameter int WRITE_PORTS = RF_WRITE_PORTS
) (
  input  logic                              clk,
  input  logic                              sync_rst,
  input  logic                              clk_en,
  input  logic [SRC_COUNT-1:0]              src_valid,
  input  logic [ADDR_WIDTH*SRC_COUNT-1:0]   src_addr,
  input  logic [DATA_WIDTH*SRC_COUNT-1:0]   src_data,
  output logic [SRC_COUNT-1:0]              src_ready,
  output logic [WRITE_PORTS-1:0]            wr_en,
  output logic [ADDR_WIDTH*WRITE_PORTS-1:0] addr,
  output logic [DATA_WIDTH*WRITE_PORTS-1:0] wr_data
);
  localparam int SW = ptr_width(SRC_COUNT);
  localparam int PW = ptr_width(WRITE_PORTS);

  logic [ADDR_WIDTH-1:0]  sa [SRC_COUNT];
  logic [DATA_WIDTH-1:0]  sd [SRC_COUNT];
  logic [SRC_COUNT-1:0]   grant;
  logic [SW-1:0]          port_src [WRITE_PORTS];
  logic [WRITE_PORTS-1:0] port_vld;
  logic [ADDR_WIDTH-1:0]  nxt_addr [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]  nxt_data [WRITE_PORTS];
  logic [SW-1:0]          last;
  logic [SW-1:0]          nxt_ptr;

  logic [SW-1:0]          rr_ptr;
  logic [WRITE_PORTS-1:0] wr_en_p1;
  logic [ADDR_WIDTH-1:0]  addr_p1 [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]  data_p1 [WRITE_PORTS];

  for (genvar i = 0; i < SRC_COUNT; i++) begin : g_src
    assign sa[i] = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign sd[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_multi_grant_picker #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .SRC_COUNT   (SRC_COUNT),
    .WRITE_PORTS (WRITE_PORTS)
  ) u_picker (
    .valid    (src_valid),
    .addrs    (sa),
    .ptr      (rr_ptr),
    .grant    (grant),
    .port_src (port_src),
    .port_vld (port_vld)
  );

  // Handshakes only complete on edges that actually update state.
  assign src_ready = (clk_en && !sync_rst) ? grant : '0;

  for (genvar k = 0; k < WRITE_PORTS; k++) begin : g_port
    assign nxt_addr[k] = port_vld[k] ? sa[port_src[k]] : '0;
    assign nxt_data[k] = port_vld[k] ? sd[port_src[k]] : '0;
    assign addr[k*ADDR_WIDTH +: ADDR_WIDTH]    = addr_p1[k];
    assign wr_data[k*DATA_WIDTH +: DATA_WIDTH] = data_p1[k];
  end

  // Pointer moves just past the last source granted in scan order.
  always_comb begin
    last = '0;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      if (port_vld[PW'(k)]) last = port_src[PW'(k)];
    end
    if (port_vld == '0)                     nxt_ptr = rr_ptr;
    else if (last == SW'(SRC_COUNT - 1))    nxt_ptr = '0;
    else                                    nxt_ptr = last + SW'(1);
  end

  // p1: registered write-port bundle
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rr_ptr   <= '0;
      wr_en_p1 <= '0;
      addr_p1  <= '{default: '0};
      data_p1  <= '{default: '0};
    end else if (clk_en) begin
      rr_ptr   <= nxt_ptr;
      wr_en_p1 <= port_vld;
      addr_p1  <= nxt_addr;
      data_p1  <= nxt_data;
    end
  end

  assign wr_en = wr_en_p1;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: vector table plus scoreboard of
// expected write-port bundles, with reset, freeze, conflict and fairness runs.
module tb_regfile_writeback_arbiter;
  import regfile_pkg::*;

  localparam int DW = 64;
  localparam int AW = 8;
  localparam int NS = 6;
  localparam int NP = 4;

  logic             clk = 1'b0;
  logic             sync_rst;
  logic             clk_en;
  logic [NS-1:0]    src_valid;
  logic [AW*NS-1:0] src_addr;
  logic [DW*NS-1:0] src_data;
  logic [NS-1:0]    src_ready;
  logic [NP-1:0]    wr_en;
  logic [AW*NP-1:0] addr;
  logic [DW*NP-1:0] wr_data;

  wb_req_t req [NS];
  int      n_vec  = 0;
  int      n_miss = 0;
  bit      dup_on = 1'b0;

  typedef struct {
    string            name;
    logic [NP-1:0]    en;
    logic [AW*NP-1:0] addr;
    logic [DW*NP-1:0] data;
    logic [2:0]       ptr;
  } exp_t;

  typedef struct {
    logic [NS-1:0]    valid;
    logic [AW*NS-1:0] addrs;
    logic [NS-1:0]    ready;
    int               s0, s1, s2, s3;
    int               ptr;
  } vec_t;

  exp_t sbq[$];
  exp_t last_exp;
  vec_t tbl [10];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NS; g++) begin : g_pack
    assign src_addr[g*AW +: AW] = req[g].addr;
    assign src_data[g*DW +: DW] = req[g].data;
  end

  regfile_writeback_arbiter #(
    .DATA_WIDTH (DW),
    .REG_COUNT  (256),
    .ADDR_WIDTH (AW),
    .SRC_COUNT  (NS),
    .WRITE_PORTS(NP)
  ) dut (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .clk_en    (clk_en),
    .src_valid (src_valid),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .src_ready (src_ready),
    .wr_en     (wr_en),
    .addr      (addr),
    .wr_data   (wr_data)
  );

  function automatic logic [63:0] dat(input int tag, input int s);
    return {32'hDA7A0000 | 32'(tag), 32'(s)};
  endfunction

  function automatic logic [AW*NS-1:0] a6(input int a0, a1, a2, a3, a4, a5);
    return {8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic exp_t mk_exp(input string nm, input int s0, s1, s2, s3, input int ptr);
    exp_t e;
    int   s [NP];
    s      = '{s0, s1, s2, s3};
    e.name = nm;
    e.en   = '0;
    e.addr = '0;
    e.data = '0;
    e.ptr  = 3'(ptr);
    for (int k = 0; k < NP; k++) begin
      if (s[k] >= 0) begin
        e.en[k]            = 1'b1;
        e.addr[k*AW +: AW] = req[s[k]].addr;
        e.data[k*DW +: DW] = req[s[k]].data;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic edge_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard: output cycle with no expectation queued");
    end else begin
      e = sbq.pop_front();
      chk({e.name, "_wr_en"},   wr_en,       e.en);
      chk({e.name, "_addr"},    addr,        e.addr);
      chk({e.name, "_wr_data"}, wr_data,     e.data);
      chk({e.name, "_rr_ptr"},  dut.rr_ptr,  e.ptr);
      last_exp = e;
    end
  endtask

  // Called just after an active edge; drives valid, checks ready, then checks outputs.
  task automatic step(input string nm, input logic [NS-1:0] v, input logic [NS-1:0] rdy,
                      input int s0, s1, s2, s3, input int ptr);
    src_valid = v;
    #1;
    chk({nm, "_ready"}, src_ready, rdy);
    sbq.push_back(mk_exp(nm, s0, s1, s2, s3, ptr));
    edge_check();
  endtask

  // No two enabled ports may carry the same register in any cycle.
  always @(posedge clk) begin
    bit dup;
    #2;
    if (dup_on) begin
      dup = 1'b0;
      for (int i = 0; i < NP; i++)
        for (int j = i + 1; j < NP; j++)
          if (wr_en[i] && wr_en[j] && addr[i*AW +: AW] == addr[j*AW +: AW]) dup = 1'b1;
      n_vec++;
      if (dup) begin
        n_miss++;
        $display("FAIL no_dup_addr: wr_en=%b addr=%h has a repeated enabled address", wr_en, addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NS-1:0] rdy;
    int            w;
    exp_t          fz;

    tbl[0] = '{6'b111111, a6(10, 11, 12, 13, 14, 15), 6'b001111,  0,  1,  2,  3, 4};
    tbl[1] = '{6'b110011, a6(20, 21, 12, 13, 14, 15), 6'b110011,  4,  5,  0,  1, 2};
    tbl[2] = '{6'b001000, a6( 0,  0,  0, 30,  0,  0), 6'b001000,  3, -1, -1, -1, 4};
    tbl[3] = '{6'b000000, a6( 1,  2,  3,  4,  5,  6), 6'b000000, -1, -1, -1, -1, 4};
    tbl[4] = '{6'b111111, a6(50, 50, 50, 50, 50, 50), 6'b010000,  4, -1, -1, -1, 5};
    tbl[5] = '{6'b111111, a6( 1,  2,  1,  3,  2,  1), 6'b101010,  5,  1,  3, -1, 4};
    tbl[6] = '{6'b000101, a6( 7,  0,  8,  0,  0,  0), 6'b000101,  0,  2, -1, -1, 3};
    tbl[7] = '{6'b111111, a6(40, 41, 42, 43, 44, 45), 6'b111001,  3,  4,  5,  0, 1};
    tbl[8] = '{6'b000001, a6( 9,  0,  0,  0,  0,  0), 6'b000001,  0, -1, -1, -1, 1};
    tbl[9] = '{6'b111111, a6( 5,  5,  6,  6,  7,  8), 6'b110110,  1,  2,  4,  5, 0};

    sync_rst  = 1'b1;
    clk_en    = 1'b1;
    src_valid = '1;
    for (int s = 0; s < NS; s++) req[s] = '{addr: 8'(10 + s), data: dat(1, s)};
    @(posedge clk);
    #1;

    // Reset holds ready low and clears the port bundle and pointer.
    step("reset", 6'b111111, 6'b000000, -1, -1, -1, -1, 0);
    sync_rst = 1'b0;
    step("post_reset", 6'b000000, 6'b000000, -1, -1, -1, -1, 0);
    dup_on = 1'b1;

    for (int v = 0; v < 10; v++) begin
      for (int s = 0; s < NS; s++) begin
        req[s].addr = tbl[v].addrs[s*AW +: AW];
        req[s].data = dat(v + 10, s);
      end
      step($sformatf("vec%0d", v), tbl[v].valid, tbl[v].ready,
           tbl[v].s0, tbl[v].s1, tbl[v].s2, tbl[v].s3, tbl[v].ptr);
    end

    // Same-address conflict from pointer 0: source 3 waits one cycle.
    sync_rst = 1'b1;
    step("rst2", 6'b000000, 6'b000000, -1, -1, -1, -1, 0);
    sync_rst = 1'b0;
    req[1] = '{addr: 8'd7, data: dat(100, 1)};
    req[3] = '{addr: 8'd7, data: dat(100, 3)};
    step("conflict_a", 6'b001010, 6'b000010, 1, -1, -1, -1, 2);
    step("conflict_b", 6'b001000, 6'b001000, 3, -1, -1, -1, 4);

    // Clock enable low: no handshakes, everything holds.
    clk_en = 1'b0;
    for (int s = 0; s < NS; s++) req[s] = '{addr: 8'(60 + s), data: dat(200, s)};
    for (int c = 0; c < 3; c++) begin
      src_valid = '1;
      #1;
      chk("freeze_ready", src_ready, 6'b000000);
      fz      = last_exp;
      fz.name = "freeze";
      sbq.push_back(fz);
      edge_check();
    end
    clk_en = 1'b1;
    step("resume", 6'b111111, 6'b110011, 4, 5, 0, 1, 2);

    // Reset mid-operation wins over a low clock enable.
    sync_rst = 1'b1;
    clk_en   = 1'b0;
    step("mid_reset", 6'b111111, 6'b000000, -1, -1, -1, -1, 0);
    sync_rst = 1'b0;
    clk_en   = 1'b1;

    // Source 2 stays valid on a private register while others saturate.
    w = 0;
    for (int c = 0; c < 24; c++) begin
      for (int s = 0; s < NS; s++) begin
        req[s].addr = (s == 2) ? 8'd99 : 8'($urandom_range(0, 31));
        req[s].data = dat(300 + c, s);
      end
      src_valid = '1;
      #1;
      w++;
      rdy = src_ready;
      if (rdy[2]) begin
        n_vec++;
        w = 0;
      end else if (w >= 2) begin
        n_vec++;
        n_miss++;
        $display("FAIL fair_src2: not granted after %0d cycles, required within 2", w);
        w = 0;
      end
      @(posedge clk);
      #1;
      chk("fair_port_count", 256'($countones(wr_en)), 256'($countones(rdy)));
    end

    src_valid = '0;
    @(posedge clk);
    #3;
    dup_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
Sits directly upstream of the multiport BRAM register file. It collects write-back requests from SRC_COUNT execution-unit sources over valid/ready handshakes and grants up to WRITE_PORTS of them per cycle using round-robin arbitration. It then drives the register file's registered wr_en/addr/wr_data write-port bundles. It also guarantees that no two write ports target the same register in the same cycle.

Parameters:
DATA_WIDTH, 64, register width in bits
REG_COUNT, 256, number of architectural registers
ADDR_WIDTH, $clog2(REG_COUNT), register index width
SRC_COUNT, 6, number of write-back sources
WRITE_PORTS, 4, register-file write ports driven; must satisfy 1 <= WRITE_PORTS <= SRC_COUNT

Ports:
clk  in  1  single clock, rising edge
sync_rst  in  1  synchronous reset, active-high
clk_en  in  1  global clock enable; low freezes all state
src_valid  in  SRC_COUNT  per-source write-back request
src_addr  in  ADDR_WIDTH*SRC_COUNT  destination register per source, source i at [(i+1)*ADDR_WIDTH-1 -: ADDR_WIDTH]
src_data  in  DATA_WIDTH*SRC_COUNT  write data per source, same packing
src_ready  out  SRC_COUNT  grant; a transfer occurs when src_valid[i] && src_ready[i]
wr_en  out  WRITE_PORTS  registered write enable to register file
addr  out  ADDR_WIDTH*WRITE_PORTS  registered write address per port
wr_data  out  DATA_WIDTH*WRITE_PORTS  registered write data per port

Behaviour:
- Reset is synchronous and active-high, on sync_rst at a rising clk edge, and takes effect regardless of clk_en. It sets wr_en=0, addr=0, wr_data=0 and rr_ptr=0. src_ready is forced to 0 combinationally while sync_rst=1.
- rr_ptr is a $clog2(SRC_COUNT)-bit pointer and is always < SRC_COUNT.
- Scan order each cycle: sources rr_ptr, rr_ptr+1, ... modulo SRC_COUNT, wrapping around.
- A source is granted when all of the following hold:
  - src_valid is 1;
  - fewer than WRITE_PORTS grants have been made earlier in the scan;
  - its src_addr does not equal the src_addr of any source already granted earlier in this scan.
- A source whose address conflicts with an earlier grant is deferred. Its src_ready stays 0, and it must hold valid/addr/data stable until granted (AXI-style; ready may depend on valid).
- src_ready is combinational from src_valid, src_addr, rr_ptr and clk_en. It is all-zero when clk_en=0 or sync_rst=1.
- Port mapping: the k-th grant in scan order (k=0..) is registered into write port k on the next edge (latency 1: handshake in cycle N -> wr_en[k]=1 in cycle N+1). Ports with no grant register wr_en=0, addr=0, wr_data=0.
- rr_ptr update on a clk_en edge:
  - if at least one grant: (index of last granted source + 1) mod SRC_COUNT;
  - otherwise: unchanged.
- Fairness guarantee: a continuously valid, non-conflicting source is granted within ceil(SRC_COUNT/WRITE_PORTS) cycles.
- clk_en=0: outputs and rr_ptr hold their values, and no handshakes occur.
- Reset mid-operation: requests pending in that cycle are not accepted, and registered port contents are cleared on that edge.
- Same-cycle conflicting writes never reach the register file. Writes to the same address in consecutive cycles are issued in arbitration order.

Decomposition:
- Shared package regfile_pkg:
  - DATA_WIDTH/REG_COUNT/ADDR_WIDTH defaults;
  - typedef wb_req_t {logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] data;};
  - localparam for the rr_ptr width.
- One sub-module, rr_multi_grant_picker: purely combinational. Inputs are the valid vector, address vector and pointer. Outputs are the grant mask, per-port source index and per-port valid. The parent registers the outputs and updates the pointer.

Test Plan:
- Reset with all src_valid=1 -> src_ready=0; the cycle after reset deasserts, wr_en=0000, addr=0 and wr_data=0.
- SRC_COUNT=6, WRITE_PORTS=4, rr_ptr=0, sources 0..5 valid to regs 10..15 -> grants 0-3. Next cycle: wr_en=1111, ports carry regs 10,11,12,13, and rr_ptr=4.
- Sources 4,5 still valid, plus 0,1 re-asserted to regs 20,21 -> scan 4,5,0,1 granted in that port order, and rr_ptr=2.
- Sources 1 and 3 both target reg 7, rr_ptr=0 -> source 1 is granted to port 0 and source 3 is deferred. The following cycle source 3 is granted and port 0 carries reg 7 with source 3's data.
- clk_en=0 for 3 cycles with requests pending -> src_ready=0 and outputs/rr_ptr frozen. On re-enable, arbitration resumes from the held rr_ptr.
- Source 2 continuously valid while all others saturate -> source 2 is granted within 2 cycles; a checker confirms no duplicate addr among enabled ports in any cycle.
